// File: rtl/bp_nonsynth_pkg.sv
// Shared types for the non-synthesizable BedRock memory-interface checkers.
// Error codes are ordered to match the encoding on error_code_o.
package bp_nonsynth_pkg;

    typedef enum logic [2:0] {
        e_chk_none     = 3'd0,
        e_chk_overflow = 3'd1,
        e_chk_orphan   = 3'd2,
        e_chk_timeout  = 3'd3,
        e_chk_size     = 3'd4
    } bp_mem_chk_err_e;

    typedef enum logic {
        e_ok    = 1'b0,
        e_error = 1'b1
    } bp_mem_chk_state_e;

endpackage

// File: rtl/bp_nonsynth_mem_chk_age.sv
// Per-entry saturating age counter, zeroed on allocate or retire.
// hit is a registered one-cycle pulse following the edge where age reaches timeout_p.
module bp_nonsynth_mem_chk_age
    import bp_nonsynth_pkg::*;
#(
    parameter int timeout_p = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               v,
    input  logic                               clr,
    output logic [$clog2(timeout_p+1)-1:0]     age,
    output logic                               hit
);

    localparam int age_w_lp = $clog2(timeout_p + 1);
    localparam logic [age_w_lp-1:0] age_max_lp  = age_w_lp'(timeout_p);
    localparam logic [age_w_lp-1:0] age_last_lp = age_w_lp'(timeout_p - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
            hit <= 1'b0;
        end else begin
            // Saturation makes the pulse fire once per entry lifetime.
            hit <= v && !clr && (age == age_last_lp);
            if (clr) begin
                age <= '0;
            end else if (v && (age != age_max_lp)) begin
                age <= age + age_w_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_priority_encode.sv
// Priority encoder: index of the lowest (lo_to_hi_p=1) or highest set request bit.
// Purely combinational; found is low when no request bit is set.
module bsg_priority_encode #(
    parameter int width_p    = 8,
    parameter bit lo_to_hi_p = 1'b1
) (
    input  logic [width_p-1:0]                                 req,
    output logic [((width_p > 1) ? $clog2(width_p) : 1)-1:0]   idx,
    output logic                                               found
);

    localparam int idx_w_lp = (width_p > 1) ? $clog2(width_p) : 1;

    // Later loop iterations overwrite earlier ones, so scan toward the winning end.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        if (lo_to_hi_p) begin
            for (int k = width_p - 1; k >= 0; k--) begin
                if (req[k]) begin
                    idx   = idx_w_lp'(k);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < width_p; k++) begin
                if (req[k]) begin
                    idx   = idx_w_lp'(k);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bp_nonsynth_mem_outstanding_checker.sv
// Snoops BedRock mem_cmd/mem_resp handshakes, tracks outstanding commands and latches the first protocol error.
// Outputs are registered and reflect the table after each edge; the snooped channels are never backpressured.
module bp_nonsynth_mem_outstanding_checker
    import bp_nonsynth_pkg::*;
#(
    parameter int els_p            = 8,
    parameter int addr_width_p     = 40,
    parameter int msg_type_width_p = 4,
    parameter int size_width_p     = 3,
    parameter int timeout_p        = 1024,
    parameter bit report_p         = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          mem_cmd_v_i,
    input  logic                          mem_cmd_ready_and_i,
    input  logic [addr_width_p-1:0]       mem_cmd_addr_i,
    input  logic [msg_type_width_p-1:0]   mem_cmd_type_i,
    input  logic [size_width_p-1:0]       mem_cmd_size_i,
    input  logic                          mem_resp_v_i,
    input  logic                          mem_resp_ready_and_i,
    input  logic [addr_width_p-1:0]       mem_resp_addr_i,
    input  logic [msg_type_width_p-1:0]   mem_resp_type_i,
    input  logic [size_width_p-1:0]       mem_resp_size_i,
    output logic [$clog2(els_p+1)-1:0]    outstanding_o,
    output logic [$clog2(els_p+1)-1:0]    max_outstanding_o,
    output logic                          error_o,
    output logic [2:0]                    error_code_o
);

    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int age_w_lp = $clog2(timeout_p + 1);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [els_p-1:0]                        v_r;
    logic [els_p-1:0][addr_width_p-1:0]      addr_r;
    logic [els_p-1:0][msg_type_width_p-1:0]  type_r;
    logic [els_p-1:0][size_width_p-1:0]      size_r;
    logic [els_p-1:0][age_w_lp-1:0]          age;
    logic [els_p-1:0]                        hit;

    logic [cnt_w_lp-1:0]  cnt_r, cnt_n, max_r;
    bp_mem_chk_state_e    state_r;
    bp_mem_chk_err_e      code_r, err_code;

    logic cmd_hs, resp_hs;
    assign cmd_hs  = mem_cmd_v_i  & mem_cmd_ready_and_i;
    assign resp_hs = mem_resp_v_i & mem_resp_ready_and_i;

    logic [els_p-1:0]    cand, cand_old;
    logic [age_w_lp-1:0] max_age;

    // Oldest matching entry wins; equal ages resolve to the lowest index via the encoder.
    always_comb begin
        max_age = '0;
        for (int i = 0; i < els_p; i++) begin
            cand[i] = v_r[i] && (addr_r[i] == mem_resp_addr_i) && (type_r[i] == mem_resp_type_i);
            if (cand[i] && (age[i] > max_age)) begin
                max_age = age[i];
            end
        end
        for (int i = 0; i < els_p; i++) begin
            cand_old[i] = cand[i] && (age[i] == max_age);
        end
    end

    logic [idx_w_lp-1:0] match_idx, alloc_idx;
    logic                match_found, free_found;
    logic [els_p-1:0]    match_oh, alloc_oh, free_vec;
    logic                match_hs, alloc;

    bsg_priority_encode #(.width_p(els_p), .lo_to_hi_p(1'b1)) u_match_pe (
        .req   (cand_old),
        .idx   (match_idx),
        .found (match_found)
    );

    assign match_hs = resp_hs && match_found;
    assign match_oh = match_hs ? (els_p'(1) << match_idx) : '0;
    assign free_vec = ~v_r | match_oh;

    bsg_priority_encode #(.width_p(els_p), .lo_to_hi_p(1'b1)) u_free_pe (
        .req   (free_vec),
        .idx   (alloc_idx),
        .found (free_found)
    );

    assign alloc    = cmd_hs && free_found;
    assign alloc_oh = alloc ? (els_p'(1) << alloc_idx) : '0;

    for (genvar g = 0; g < els_p; g++) begin : g_age
        bp_nonsynth_mem_chk_age #(.timeout_p(timeout_p)) u_age (
            .clk   (clk_i),
            .rst_n (reset_n_i),
            .v     (v_r[g]),
            .clr   (alloc_oh[g] | match_oh[g]),
            .age   (age[g]),
            .hit   (hit[g])
        );
    end

    logic ovf, orph, szm, tmo, err_vld;
    assign ovf     = cmd_hs && !free_found;
    assign orph    = resp_hs && !match_found;
    assign szm     = match_hs && (size_r[match_idx] != mem_resp_size_i);
    assign tmo     = |hit;
    assign err_vld = ovf | orph | szm | tmo;

    always_comb begin
        err_code = e_chk_none;
        if (ovf)       err_code = e_chk_overflow;
        else if (orph) err_code = e_chk_orphan;
        else if (szm)  err_code = e_chk_size;
        else if (tmo)  err_code = e_chk_timeout;
    end

    assign cnt_n = cnt_r + cnt_w_lp'(alloc) - cnt_w_lp'(match_hs);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r     <= '0;
            addr_r  <= '0;
            type_r  <= '0;
            size_r  <= '0;
            cnt_r   <= '0;
            max_r   <= '0;
            state_r <= e_ok;
            code_r  <= e_chk_none;
        end else begin
            v_r <= (v_r & ~match_oh) | alloc_oh;
            if (alloc) begin
                addr_r[alloc_idx] <= mem_cmd_addr_i;
                type_r[alloc_idx] <= mem_cmd_type_i;
                size_r[alloc_idx] <= mem_cmd_size_i;
            end
            cnt_r <= cnt_n;
            max_r <= (cnt_n > max_r) ? cnt_n : max_r;
            if ((state_r == e_ok) && err_vld) begin
                state_r <= e_error;
                code_r  <= err_code;
            end
        end
    end

    assign outstanding_o     = cnt_r;
    assign max_outstanding_o = max_r;
    assign error_o           = (state_r == e_error);
    assign error_code_o      = code_r;

    logic [addr_width_p-1:0] tmo_addr;
    always_comb begin
        tmo_addr = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (hit[i]) tmo_addr = addr_r[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (report_p && reset_n_i) begin
            if (ovf)  $error("[%0t] mem checker: overflow (code 1) addr=%h", $time, mem_cmd_addr_i);
            if (orph) $error("[%0t] mem checker: orphan response (code 2) addr=%h", $time, mem_resp_addr_i);
            if (tmo)  $error("[%0t] mem checker: timeout (code 3) addr=%h", $time, tmo_addr);
            if (szm)  $error("[%0t] mem checker: size mismatch (code 4) addr=%h", $time, mem_resp_addr_i);
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_mem_outstanding_checker.sv
// Self-checking bench: vector table, directed corner sequences, and randomized traffic vs. a table model.
module tb_bp_nonsynth_mem_outstanding_checker;

    localparam int ELS = 8;
    localparam int TMO = 16;
    localparam logic [3:0] RD = 4'h1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cmd_v, cmd_rdy, resp_v, resp_rdy;
    logic [39:0] cmd_addr, resp_addr;
    logic [3:0]  cmd_type, resp_type;
    logic [2:0]  cmd_size, resp_size;
    logic [3:0]  outstanding, max_out;
    logic        error;
    logic [2:0]  code;

    bp_nonsynth_mem_outstanding_checker #(
        .els_p(ELS), .addr_width_p(40), .msg_type_width_p(4), .size_width_p(3),
        .timeout_p(TMO), .report_p(1'b0)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_v_i(cmd_v), .mem_cmd_ready_and_i(cmd_rdy), .mem_cmd_addr_i(cmd_addr),
        .mem_cmd_type_i(cmd_type), .mem_cmd_size_i(cmd_size),
        .mem_resp_v_i(resp_v), .mem_resp_ready_and_i(resp_rdy), .mem_resp_addr_i(resp_addr),
        .mem_resp_type_i(resp_type), .mem_resp_size_i(resp_size),
        .outstanding_o(outstanding), .max_outstanding_o(max_out),
        .error_o(error), .error_code_o(code)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain array of outstanding requests.
    bit          m_v[ELS];
    logic [39:0] m_addr[ELS];
    logic [3:0]  m_type[ELS];
    logic [2:0]  m_size[ELS];
    int          m_age[ELS];
    bit          m_tpend;
    int          m_cnt, m_max, m_code;
    bit          m_err;

    function automatic void model_reset();
        for (int i = 0; i < ELS; i++) begin
            m_v[i] = 0; m_age[i] = 0;
        end
        m_tpend = 0; m_cnt = 0; m_max = 0; m_err = 0; m_code = 0;
    endfunction

    function automatic void model_step();
        int match, slot;
        bit chs, rhs, ovf, orph, szm, tmo;
        match = -1; slot = -1; ovf = 0; orph = 0; szm = 0;
        chs = cmd_v && cmd_rdy;
        rhs = resp_v && resp_rdy;
        tmo = m_tpend;
        m_tpend = 0;
        if (rhs) begin
            for (int i = 0; i < ELS; i++)
                if (m_v[i] && m_addr[i] == resp_addr && m_type[i] == resp_type &&
                    (match < 0 || m_age[i] > m_age[match]))
                    match = i;
            if (match < 0) orph = 1;
            else if (m_size[match] != resp_size) szm = 1;
        end
        if (chs) begin
            for (int i = ELS - 1; i >= 0; i--)
                if (!m_v[i] || i == match) slot = i;
            if (slot < 0) ovf = 1;
        end
        for (int i = 0; i < ELS; i++) begin
            if (m_v[i] && i != match) begin
                if (m_age[i] == TMO - 1) m_tpend = 1;
                if (m_age[i] < TMO) m_age[i]++;
            end
        end
        if (match >= 0) m_v[match] = 0;
        if (slot >= 0) begin
            m_v[slot] = 1; m_addr[slot] = cmd_addr; m_type[slot] = cmd_type;
            m_size[slot] = cmd_size; m_age[slot] = 0;
        end
        m_cnt = 0;
        for (int i = 0; i < ELS; i++) m_cnt += int'(m_v[i]);
        if (m_cnt > m_max) m_max = m_cnt;
        if (!m_err && (ovf || orph || szm || tmo)) begin
            m_err = 1;
            m_code = ovf ? 1 : orph ? 2 : szm ? 4 : 3;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model outstanding", outstanding, m_cnt);
        check("model max", max_out, m_max);
        check("model error", error, m_err);
        check("model code", code, m_code);
    endtask

    task automatic set_idle();
        cmd_v = 0; cmd_rdy = 1; cmd_addr = '0; cmd_type = RD; cmd_size = 3'd3;
        resp_v = 0; resp_rdy = 1; resp_addr = '0; resp_type = RD; resp_size = 3'd3;
    endtask

    task automatic do_cmd(input logic [39:0] a, input logic [2:0] s);
        cmd_v = 1; cmd_addr = a; cmd_type = RD; cmd_size = s;
    endtask

    task automatic do_resp(input logic [39:0] a, input logic [2:0] s);
        resp_v = 1; resp_addr = a; resp_type = RD; resp_size = s;
    endtask

    // Asserted away from the clock edge; outputs must clear without waiting for one.
    task automatic do_reset();
        rst_n = 0;
        #1;
        check("reset outstanding", outstanding, 0);
        check("reset max", max_out, 0);
        check("reset error", error, 0);
        check("reset code", code, 0);
        model_reset();
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    typedef struct {
        bit          cv;
        logic [39:0] ca;
        bit          rv;
        logic [39:0] ra;
        logic [2:0]  rs;
        int          e_out;
        int          e_max;
        bit          e_err;
        int          e_code;
    } vec_t;

    vec_t        vt[8];
    logic [39:0] pool[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1, 40'h80000000, 0, 40'h0,        3'd3, 1, 1, 0, 0};
        vt[1] = '{1, 40'h40,       0, 40'h0,        3'd3, 2, 2, 0, 0};
        vt[2] = '{1, 40'h80,       0, 40'h0,        3'd3, 3, 3, 0, 0};
        vt[3] = '{0, 40'h0,        1, 40'h80,       3'd3, 2, 3, 0, 0};
        vt[4] = '{0, 40'h0,        1, 40'h40,       3'd3, 1, 3, 0, 0};
        vt[5] = '{0, 40'h0,        1, 40'h80000000, 3'd3, 0, 3, 0, 0};
        vt[6] = '{0, 40'h0,        0, 40'h0,        3'd3, 0, 3, 0, 0};
        vt[7] = '{0, 40'h0,        1, 40'h1000,     3'd3, 0, 3, 1, 2};
        pool[0] = 40'h80000000; pool[1] = 40'h40; pool[2] = 40'h80; pool[3] = 40'hC0;

        set_idle();
        rst_n = 1;
        #2;
        do_reset();

        // Three reads retired in reverse order, then an orphan.
        for (int k = 0; k < 8; k++) begin
            set_idle();
            cmd_v = vt[k].cv; cmd_addr = vt[k].ca;
            resp_v = vt[k].rv; resp_addr = vt[k].ra; resp_size = vt[k].rs;
            tick();
            check($sformatf("vec%0d outstanding", k), outstanding, vt[k].e_out);
            check($sformatf("vec%0d max", k), max_out, vt[k].e_max);
            check($sformatf("vec%0d error", k), error, vt[k].e_err);
            check($sformatf("vec%0d code", k), code, vt[k].e_code);
        end

        // Nine commands into eight slots.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_idle();
            do_cmd(40'h100 + 40'(i * 64), 3'd3);
            tick();
            if (i == 7) begin
                check("fill8 outstanding", outstanding, 8);
                check("fill8 error", error, 0);
            end
        end
        check("overflow outstanding", outstanding, 8);
        check("overflow error", error, 1);
        check("overflow code", code, 1);

        // Orphan first; a later overflow must not replace the code.
        do_reset();
        do_resp(40'h1000, 3'd3);
        tick();
        check("orphan code", code, 2);
        check("orphan error", error, 1);
        for (int i = 0; i < 9; i++) begin
            set_idle();
            do_cmd(40'h100 + 40'(i * 64), 3'd3);
            tick();
        end
        check("sticky code", code, 2);
        check("sticky outstanding", outstanding, 8);

        // Full table: a response frees entry 3 in the same cycle a new command arrives.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_idle();
            do_cmd(40'h100 + 40'(i * 64), 3'd3);
            tick();
        end
        set_idle();
        do_cmd(40'h5000, 3'd3);
        do_resp(40'h100 + 40'(3 * 64), 3'd3);
        tick();
        check("swap error", error, 0);
        check("swap outstanding", outstanding, 8);
        set_idle();
        do_resp(40'h5000, 3'd3);
        tick();
        check("swap new entry error", error, 0);
        check("swap new entry outstanding", outstanding, 7);
        set_idle();
        do_resp(40'h100 + 40'(3 * 64), 3'd3);
        tick();
        check("swap old entry gone", code, 2);

        // Timeout: code appears 17 edges after the command edge.
        do_reset();
        do_cmd(40'h2000, 3'd3);
        tick();
        set_idle();
        for (int j = 1; j <= TMO; j++) tick();
        check("pre-timeout code", code, 0);
        tick();
        check("timeout code", code, 3);
        check("timeout outstanding", outstanding, 1);
        do_resp(40'h2000, 3'd3);
        tick();
        check("late resp outstanding", outstanding, 0);
        check("late resp code", code, 3);

        // Size mismatch, then reset in the middle of a burst.
        do_reset();
        do_cmd(40'h3000, 3'd3);
        tick();
        set_idle();
        do_resp(40'h3000, 3'd6);
        tick();
        check("size code", code, 4);
        check("size outstanding", outstanding, 0);
        set_idle();
        for (int i = 0; i < 3; i++) begin
            do_cmd(40'h4000 + 40'(i * 64), 3'd3);
            tick();
        end
        check("burst outstanding", outstanding, 3);
        do_reset();

        // Randomized traffic with occasional resets to re-arm the sticky error.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                cmd_v     = $urandom_range(0, 1);
                cmd_rdy   = ($urandom_range(0, 3) != 0);
                cmd_addr  = pool[$urandom_range(0, 3)];
                cmd_type  = 4'($urandom_range(0, 1));
                cmd_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
                resp_v    = ($urandom_range(0, 2) == 0);
                resp_rdy  = ($urandom_range(0, 3) != 0);
                resp_addr = pool[$urandom_range(0, 3)];
                resp_type = 4'($urandom_range(0, 1));
                resp_size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_mem_outstanding_checker.md
Name: bp_nonsynth_mem_outstanding_checker

Overview:
Non-synthesizable checker bound downstream of the configuration checks, alongside the CCE-to-memory BedRock interface. It snoops mem_cmd and mem_resp handshakes and keeps a table of outstanding commands. It flags protocol violations: table overflow, orphan responses, size mismatches and timeouts. It reports occupancy and a sticky error code for testbench or trace consumption.

Parameters:
els_p, 8, max tracked outstanding commands (≥1)
addr_width_p, 40, paddr width of snooped headers
msg_type_width_p, 4, BedRock mem msg_type width
size_width_p, 3, BedRock msg size field width
timeout_p, 1024, cycles an entry may stay outstanding before timeout error (≥2)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
mem_cmd_v_i  in  1  snooped command valid
mem_cmd_ready_and_i  in  1  snooped command ready; handshake = v & ready
mem_cmd_addr_i  in  addr_width_p  command address
mem_cmd_type_i  in  msg_type_width_p  command msg_type
mem_cmd_size_i  in  size_width_p  command size
mem_resp_v_i  in  1  snooped response valid
mem_resp_ready_and_i  in  1  snooped response ready
mem_resp_addr_i  in  addr_width_p  response address
mem_resp_type_i  in  msg_type_width_p  response msg_type
mem_resp_size_i  in  size_width_p  response size
outstanding_o  out  $clog2(els_p+1)  current valid entry count
max_outstanding_o  out  $clog2(els_p+1)  high-water mark of outstanding_o
error_o  out  1  sticky: any error since reset
error_code_o  out  3  code of first error: 0 none, 1 overflow, 2 orphan, 3 timeout, 4 size mismatch

Behaviour:
- Reset (async, reset_n_i=0): all entries invalid; ages 0; outstanding_o=0, max_outstanding_o=0, error_o=0, error_code_o=0; FSM to e_ok. Reset mid-traffic discards all entries with no error.
- Entry = {v, addr, type, size, age[$clog2(timeout_p+1)]}.
- Response handshake: match candidates are valid entries with equal addr and type, evaluated on pre-edge table. Pick the candidate with the largest age; ties go to the lowest index. Clear it at the edge. If no candidate: orphan (2). If matched and size differs: size mismatch (4); entry still cleared.
- Command handshake: free vector = ~v | matched_onehot. A slot freed by a same-cycle response is reusable. Allocate the lowest free index with age=0. If no free slot: overflow (1), command dropped.
- A same-cycle command cannot satisfy a same-cycle response; the response sees only the pre-edge table.
- Age: every valid entry increments by 1 per cycle, saturating at timeout_p. When an entry's age reaches timeout_p: timeout (3) on that cycle only, once per entry; entry remains valid until matched.
- outstanding_o updates registered, 1 cycle after the handshake edge. Net change per cycle is in {-1,0,+1}. max_outstanding_o = max(prev, new outstanding).
- Error FSM, two states. e_ok → e_error on the first error; record error_code_o. e_error is absorbing until reset; later errors do not change the code.
- Priority when several errors occur in one cycle: overflow > orphan > size mismatch > timeout.
- Each error issues a $error with code, address and time. No $fatal, so the bench decides whether to stop.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package bp_nonsynth_pkg holds: enum bp_mem_chk_err_e {e_chk_none, e_chk_overflow, e_chk_orphan, e_chk_timeout, e_chk_size}; FSM enum {e_ok, e_error}.
- One sub-module, bp_nonsynth_mem_chk_age: per-entry saturating age counter with clear-on-alloc. It outputs a one-cycle hit pulse when age reaches timeout_p.
- Lowest-free and match select reuse bsg_priority_encode.

Test Plan:
- 3 cmds (addr 0x80000000/0x40/0x80, type rd, size 3), then responses in reverse order → outstanding_o 0→3→0; max_outstanding_o=3; error_o=0.
- 9 cmd handshakes with els_p=8 and no responses → outstanding_o=8, error_o=1, error_code_o=1 the cycle after the 9th.
- Response handshake addr 0x1000 with empty table → error_code_o=2 one cycle later; a subsequent overflow leaves the code at 2.
- Table full; same-cycle response matching entry 3 plus new cmd → no error; new cmd lands in entry 3; outstanding_o stays 8.
- timeout_p=16; one cmd with no response → error_code_o=3 registered 17 cycles after the cmd edge; a late matching response clears it with no orphan.
- Cmd size 3, response same addr/type size 6 → error_code_o=4, outstanding_o returns to 0; assert reset_n_i low mid-burst → all outputs 0 immediately.
